// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from imem, hands it to decode.
// Latency: ack at cycle T -> instr_valid at T+1; with 1-cycle memory and ready high, 1 instr per 3 cycles.
// Backpressure: holds instr/instr_pc in OUT until decode takes it; no new fetch while held or halted.
// Optional: define FETCH_PERF_CNT_EN to add the fetch_count port (completed decode transfers).
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count
`endif
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_OUT  = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   state_t state;
   // Set when the fetch currently in flight was issued on a path that has since been redirected.
   logic   drop;

   // Request is a one-cycle pulse from REQ; reset gating keeps it low while rst is asserted.
   assign imem_req  = rst && (state == ST_REQ) && !halt;
   assign imem_addr = pc;

   // Fetch sequencing, PC update and output holding register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_REQ;
         pc          <= RESET_PC;
         instr       <= 32'd0;
         instr_pc    <= 32'd0;
         instr_valid <= 1'b0;
         drop        <= 1'b0;
      end else begin
         case (state)
            ST_REQ: begin
               if (redirect)
                  pc <= redirect_pc;
               if (halt) begin
                  state <= ST_HALT;
               end else begin
                  // The request just issued targets the old pc; a redirect now makes it stale.
                  state <= ST_WAIT;
                  drop  <= redirect;
               end
            end
            ST_WAIT: begin
               if (imem_ack) begin
                  if (drop || redirect) begin
                     // Returning word belongs to an abandoned path; refetch from the current pc.
                     drop  <= 1'b0;
                     state <= ST_REQ;
                     if (redirect)
                        pc <= redirect_pc;
                  end else begin
                     instr       <= imem_data;
                     instr_pc    <= pc;
                     pc          <= pc + PC_INC;
                     instr_valid <= 1'b1;
                     state       <= ST_OUT;
                  end
               end else if (redirect) begin
                  pc   <= redirect_pc;
                  drop <= 1'b1;
               end
            end
            ST_OUT: begin
               if (redirect)
                  pc <= redirect_pc;
               // Leave on a transfer, or discard the held instruction when redirected without one.
               if (instr_ready || redirect) begin
                  instr_valid <= 1'b0;
                  state       <= ST_REQ;
               end
            end
            ST_HALT: begin
               if (redirect)
                  pc <= redirect_pc;
               if (!halt)
                  state <= ST_REQ;
            end
            default: state <= ST_REQ;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Count every completed transfer to decode, wrapping at 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fetch_count <= 32'd0;
      else if (instr_valid && instr_ready)
         fetch_count <= fetch_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RESET_PC), .PC_INC(32'd1)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .pc          (pc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count (fetch_count)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: transaction view of the fetch stage.
   logic [31:0] m_pc;        // next address to fetch
   logic        m_busy;      // a memory fetch is outstanding
   logic        m_stale;     // outstanding fetch was overtaken by a redirect
   logic        m_have;      // an instruction is waiting for decode
   logic        m_halted;    // parked because halt was seen when about to fetch
   logic [31:0] m_instr;
   logic [31:0] m_ipc;
   logic [31:0] m_cnt;
   logic [31:0] m_req_addr;  // address of outstanding fetch, used by the memory model
   int          mem_lat;     // remaining idle cycles before the memory acks

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a + 32'hA000;
   endfunction

   function automatic bit will_req();
      return !m_busy && !m_have && !m_halted;
   endfunction

   task automatic model_reset();
      m_pc = RESET_PC; m_busy = 0; m_stale = 0; m_have = 0; m_halted = 0;
      m_instr = 0; m_ipc = 0; m_cnt = 0; m_req_addr = 0; mem_lat = 0;
   endtask

   // One clock cycle; entered and left at a falling edge.
   task automatic cycle(input logic h, input logic rd, input logic [31:0] rpc,
                        input logic rdy, input int lat, input logic sp);
      logic exp_req;
      halt = h; redirect = rd; redirect_pc = rpc; instr_ready = rdy;
      if (m_busy) begin
         if (mem_lat == 0) begin
            imem_ack = 1'b1; imem_data = mem_word(m_req_addr);
         end else begin
            imem_ack = 1'b0; imem_data = $urandom; mem_lat--;
         end
      end else begin
         imem_ack = sp; imem_data = $urandom;
      end
      exp_req = will_req() && !h;
      #1;
      check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      check("imem_addr", imem_addr, m_pc);
      check("pc", pc, m_pc);
      check("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
      if (m_have) begin
         check("instr", instr, m_instr);
         check("instr_pc", instr_pc, m_ipc);
      end
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count", fetch_count, m_cnt);
`endif
      // Advance the model to what the next edge should produce.
      if (m_have) begin
         if (rdy) m_cnt = m_cnt + 1;
         if (rdy || rd) m_have = 0;
         if (rd) m_pc = rpc;
      end else if (m_halted) begin
         if (rd) m_pc = rpc;
         if (!h) m_halted = 0;
      end else if (!m_busy) begin
         if (h) m_halted = 1;
         else begin
            m_busy = 1; m_stale = rd; m_req_addr = m_pc; mem_lat = lat;
         end
         if (rd) m_pc = rpc;
      end else if (imem_ack) begin
         m_busy = 0;
         if (m_stale || rd) begin
            m_stale = 0;
            if (rd) m_pc = rpc;
         end else begin
            m_have = 1; m_instr = imem_data; m_ipc = m_pc; m_pc = m_pc + 32'd1;
         end
      end else if (rd) begin
         m_pc = rpc; m_stale = 1;
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 0, 1'b0);
   endtask

   // Assert reset away from any clock edge, with a stray ack on the bus throughout.
   task automatic do_reset(input logic h);
      #2;
      rst = 1'b0; imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
      halt = h; redirect = 1'b0; instr_ready = 1'b1;
      #1;
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_pc", pc, RESET_PC);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_fetch_count", fetch_count, 32'd0);
`endif
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      // First cycle out of reset: late ack still high while in REQ must be ignored.
      cycle(h, 1'b0, 32'd0, 1'b1, 0, 1'b1);
   endtask

   initial begin
      logic [31:0] rpc;
      rst = 1'b0; imem_ack = 0; imem_data = 0; redirect = 0; redirect_pc = 0;
      halt = 0; instr_ready = 1;
      model_reset();
      @(negedge clk);

      // Streaming: 1-cycle memory, ready high.
      do_reset(1'b0);
      run(9);

      // Decode stalls for several cycles in OUT.
      for (int i = 0; i < 20 && !m_have; i++) run(1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 0, 1'b0);
      run(6);

      // Redirect while waiting on a slow fetch.
      for (int i = 0; i < 20 && !will_req(); i++) run(1);
      cycle(1'b0, 1'b0, 32'd0, 1'b1, 2, 1'b0);
      cycle(1'b0, 1'b1, 32'h40, 1'b1, 0, 1'b0);
      run(8);

      // Redirect in OUT with and without ready.
      for (int i = 0; i < 20 && !m_have; i++) run(1);
      cycle(1'b0, 1'b1, 32'h80, 1'b1, 0, 1'b0);
      run(4);
      for (int i = 0; i < 20 && !m_have; i++) run(1);
      cycle(1'b0, 1'b1, 32'h80, 1'b0, 0, 1'b0);
      run(4);

      // Halted from reset, redirected while halted, then released.
      do_reset(1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b1, 0, 1'b1);
      cycle(1'b1, 1'b1, 32'h10, 1'b1, 0, 1'b0);
      cycle(1'b1, 1'b0, 32'd0, 1'b1, 0, 1'b0);
      run(6);

      // Reset while a fetch is outstanding.
      for (int i = 0; i < 20 && !will_req(); i++) run(1);
      cycle(1'b0, 1'b0, 32'd0, 1'b1, 3, 1'b0);
      run(1);
      do_reset(1'b0);
      run(6);

      // Random traffic, including targets near the top of the address space.
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(3))
            0:       rpc = 32'hFFFF_FFFF - $urandom_range(2);
            1:       rpc = $urandom_range(255);
            default: rpc = $urandom;
         endcase
         cycle($urandom_range(7) == 0, $urandom_range(5) == 0, rpc,
               $urandom_range(2) != 0, $urandom_range(3), $urandom_range(4) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute bound on run time.
   initial begin
      #500000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end

endmodule
